// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the input-FIFO to output-FIFO scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int FIFO_DEPTH  = 8;
    localparam int PTR_WIDTH   = 3;
    localparam int DATA_WIDTH  = 10;
    localparam int COUNT_WIDTH = 4;
    localparam int NUM_FIFOS   = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: first requester at or after ptr wins.
// Latency: purely combinational.
// Backpressure: en=0 suppresses every grant.
module rr_arbiter4 (
    input  logic [1:0] ptr,
    input  logic [3:0] req,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    logic [1:0] idx;

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        idx     = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (en && req[idx]) begin
                gnt     = 4'b0001 << idx;
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin mover from four FWFT input FIFOs into one output FIFO.
// Latency: pop in cycle N gives push/data_out in cycle N+1.
// Backpressure: pops stop while out_count + in-flight push reaches the threshold.
module fifo_rr_scheduler
    import fifo_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int count_width = COUNT_WIDTH,
    parameter int thr_default = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [count_width-1:0]  thr_in,
    input  logic [3:0]              fifo_empty,
    input  logic [3:0]              fifo_error,
    input  logic [4*data_width-1:0] fifo_head,
    input  logic [count_width-1:0]  out_count,
    output logic [3:0]              pop,
    output logic                    push,
    output logic [data_width-1:0]   data_out,
    output logic [2:0]              state,
    output logic                    idle,
    output logic                    error_out
);

    state_t                 state_q;
    logic [count_width-1:0] thr_q;
    logic [count_width-1:0] thr_clamped;
    logic [1:0]             ptr_q;
    logic [count_width:0]   occ;
    logic                   pop_en;
    logic [3:0]             gnt;
    logic [1:0]             gnt_idx;
    logic                   gnt_vld;

    // The in-flight push is counted so thr=8 can never overflow the output FIFO.
    assign occ    = {1'b0, out_count} + (count_width + 1)'(push);
    assign pop_en = (state_q == ST_ACTIVE) && !init && (occ < {1'b0, thr_q});

    always_comb begin
        thr_clamped = thr_in;
        if (thr_in == '0)
            thr_clamped = count_width'(1);
        else if (thr_in > count_width'(FIFO_DEPTH))
            thr_clamped = count_width'(FIFO_DEPTH);
    end

    rr_arbiter4 u_arb (
        .ptr     (ptr_q),
        .req     (~fifo_empty),
        .en      (pop_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign pop   = gnt;
    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RESET;
            thr_q     <= count_width'(thr_default);
            ptr_q     <= 2'd0;
            push      <= 1'b0;
            data_out  <= '0;
            idle      <= 1'b0;
            error_out <= 1'b0;
        end else begin
            push <= gnt_vld;
            if (gnt_vld) begin
                data_out <= fifo_head[gnt_idx*data_width +: data_width];
                ptr_q    <= gnt_idx + 2'd1;
            end
            if (state_q == ST_INIT)
                thr_q <= thr_clamped;

            case (state_q)
                ST_RESET: begin
                    state_q <= ST_INIT;
                    idle    <= 1'b0;
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    if (|fifo_error) begin
                        state_q   <= ST_ERROR;
                        idle      <= 1'b0;
                        error_out <= 1'b1;
                    end else if (init) begin
                        state_q <= ST_INIT;
                        idle    <= 1'b0;
                    end else begin
                        case (state_q)
                            ST_INIT: begin
                                if (&fifo_empty) begin
                                    state_q <= ST_IDLE;
                                    idle    <= 1'b1;
                                end else begin
                                    state_q <= ST_ACTIVE;
                                    idle    <= 1'b0;
                                end
                            end
                            ST_IDLE: begin
                                if (!(&fifo_empty)) begin
                                    state_q <= ST_ACTIVE;
                                    idle    <= 1'b0;
                                end
                            end
                            ST_ACTIVE: begin
                                if (&fifo_empty && !gnt_vld) begin
                                    state_q <= ST_IDLE;
                                    idle    <= 1'b1;
                                end
                            end
                            default: begin
                                state_q <= state_q;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: queue-based FIFO environment, rule-level reference model,
// and a scoreboard monitor matching pushed words against the words the model popped.
module tb_fifo_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic [3:0]  thr_in = 4'd0;
    logic [3:0]  fifo_empty = 4'hF;
    logic [3:0]  fifo_error = 4'h0;
    logic [39:0] fifo_head = '0;
    logic [3:0]  out_count = 4'd0;
    logic [3:0]  pop;
    logic        push;
    logic [9:0]  data_out;
    logic [2:0]  state;
    logic        idle;
    logic        error_out;

    always #5 clk = ~clk;

    fifo_rr_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .thr_in     (thr_in),
        .fifo_empty (fifo_empty),
        .fifo_error (fifo_error),
        .fifo_head  (fifo_head),
        .out_count  (out_count),
        .pop        (pop),
        .push       (push),
        .data_out   (data_out),
        .state      (state),
        .idle       (idle),
        .error_out  (error_out)
    );

    int checks = 0;
    int errors = 0;

    // Environment: input FIFOs as circular buffers, output FIFO as an occupancy count.
    logic [9:0] mem [4][8];
    int         rd  [4];
    int         cnt [4];
    int         oc;
    int         drain_pct;
    int         bp_max;

    // Reference model: states numbered 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR.
    int         m_state, m_ptr, m_thr, m_inflight;
    logic [9:0] sb [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic enq(input int i, input logic [9:0] w);
        if (cnt[i] < 8) begin
            mem[i][(rd[i] + cnt[i]) % 8] = w;
            cnt[i]++;
        end
    endtask

    function automatic int clamp_thr(input int t);
        if (t == 0) return 1;
        if (t > 8) return 8;
        return t;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]        = (cnt[i] == 0);
            fifo_head[i*10 +: 10] = (cnt[i] > 0) ? mem[i][rd[i]] : 10'd0;
        end
        out_count = 4'(oc);
    endtask

    task automatic step();
        int   g;
        int   ns;
        logic all_empty;
        drive();
        @(negedge clk);
        chk("state", int'(state), m_state);
        chk("idle", int'(idle), int'(m_state == 2));
        chk("error_out", int'(error_out), int'(m_state == 4));
        chk("push", int'(push), m_inflight);

        all_empty = 1'b1;
        for (int i = 0; i < 4; i++)
            if (cnt[i] > 0) all_empty = 1'b0;

        g = -1;
        if (m_state == 3 && !init && (oc + m_inflight) < m_thr) begin
            for (int k = 0; k < 4; k++)
                if (g < 0 && cnt[(m_ptr + k) % 4] > 0) g = (m_ptr + k) % 4;
        end
        chk("pop", int'(pop), (g >= 0) ? (1 << g) : 0);

        ns = m_state;
        case (m_state)
            0: ns = 1;
            4: ns = 4;
            default: begin
                if (m_state == 1) m_thr = clamp_thr(int'(thr_in));
                if (fifo_error != 4'h0)  ns = 4;
                else if (init)           ns = 1;
                else if (m_state == 3)   ns = (all_empty && g < 0) ? 2 : 3;
                else if (m_state == 1 || m_state == 2) ns = all_empty ? 2 : 3;
            end
        endcase
        m_state = ns;

        if (oc > 0 && int'($urandom_range(99)) < drain_pct) oc--;
        oc = oc + m_inflight;
        chk("out_fifo_bound", int'(oc <= 8), 1);
        if (oc + ((g >= 0) ? 1 : 0) > bp_max) bp_max = oc + ((g >= 0) ? 1 : 0);

        if (g >= 0) begin
            sb.push_back(mem[g][rd[g]]);
            rd[g]  = (rd[g] + 1) % 8;
            cnt[g]--;
            m_ptr  = (g + 1) % 4;
        end
        m_inflight = (g >= 0) ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        sb.delete();
        m_state    = 0;
        m_ptr      = 0;
        m_thr      = 6;
        m_inflight = 0;
        oc         = 0;
        repeat (n) begin
            drive();
            @(negedge clk);
            chk("rst_pop", int'(pop), 0);
            chk("rst_push", int'(push), 0);
            chk("rst_data_out", int'(data_out), 0);
            chk("rst_state", int'(state), 0);
            chk("rst_idle", int'(idle), 0);
            chk("rst_error_out", int'(error_out), 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic load_thr(input int t);
        init   = 1'b1;
        thr_in = 4'(t);
        step();
        step();
        init   = 1'b0;
        step();
    endtask

    // Scoreboard monitor: every push must carry the oldest word the model popped.
    always @(negedge clk) begin
        if (!reset && push) begin
            if (sb.size() == 0) begin
                chk("unexpected_push", 1, 0);
            end else begin
                chk("data_out", int'(data_out), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 4; i++) begin
            rd[i]  = 0;
            cnt[i] = 0;
        end
        drain_pct = 100;
        bp_max    = 0;

        // Reset, then INIT with threshold 5, then IDLE with everything empty.
        do_reset(3);
        init   = 1'b1;
        thr_in = 4'd5;
        step();
        step();
        init = 1'b0;
        step();
        step();
        chk("thr_after_init", int'(dut.thr_q), 5);
        chk("idle_state", int'(state), 2);

        // Round-robin over FIFOs 0, 2, 3 with threshold 8.
        load_thr(8);
        enq(0, 10'h090); enq(0, 10'h090);
        enq(2, 10'h1A9);
        enq(3, 10'h239);
        repeat (8) step();

        // Backpressure at threshold 6: no drain first, then a slow drain.
        load_thr(6);
        drain_pct = 0;
        bp_max    = 0;
        for (int k = 0; k < 8; k++) enq(1, 10'(k + 16));
        repeat (10) step();
        chk("bp_stall_occupancy", oc, 6);
        drain_pct = 40;
        repeat (20) step();
        chk("bp_max_le_thr", int'(bp_max <= 6), 1);
        drain_pct = 100;
        repeat (4) step();

        // Single source drain from FIFO 1.
        load_thr(8);
        enq(1, 10'h04F); enq(1, 10'h04D); enq(1, 10'h018);
        repeat (7) step();
        chk("drain_back_idle", int'(state), 2);

        // Mid-run init loads threshold 3 and then resumes.
        for (int k = 0; k < 6; k++) begin
            enq(k % 4, 10'($urandom));
            enq((k + 1) % 4, 10'($urandom));
        end
        repeat (3) step();
        init   = 1'b1;
        thr_in = 4'd3;
        step();
        step();
        init = 1'b0;
        repeat (4) step();
        chk("thr_mid_init", int'(dut.thr_q), 3);
        repeat (10) step();

        // Randomized traffic with occasional init episodes and clamped thresholds.
        for (int c = 0; c < 700; c++) begin
            if (c % 50 == 0) drain_pct = int'($urandom_range(100));
            if ($urandom_range(99) < 35) enq(int'($urandom_range(3)), 10'($urandom));
            if (!init && $urandom_range(99) < 3) begin
                init   = 1'b1;
                thr_in = 4'($urandom_range(15));
            end else if (init && $urandom_range(99) < 50) begin
                init = 1'b0;
            end
            step();
        end
        init = 1'b0;
        drain_pct = 100;
        repeat (30) step();

        // Error during ACTIVE is sticky until reset.
        load_thr(8);
        for (int k = 0; k < 4; k++) begin
            enq(k, 10'($urandom));
            enq(k, 10'($urandom));
        end
        t = 0;
        while (m_state != 3 && t < 10) begin
            step();
            t++;
        end
        chk("reach_active", m_state, 3);
        fifo_error = 4'b0100;
        step();
        fifo_error = 4'b0000;
        for (int k = 0; k < 4; k++) enq(k, 10'($urandom));
        repeat (6) step();
        chk("error_sticky", int'(error_out), 1);
        chk("scoreboard_drained", sb.size(), 0);
        do_reset(2);
        repeat (3) step();
        chk("error_cleared", int'(error_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Sequences four input FIFOs (depth 8, 10-bit words) into one shared output FIFO using round-robin arbitration and threshold-based backpressure.
- Sits between the four input-FIFO instances and the output-FIFO instance.
- Drives each input FIFO's pop, the output FIFO's push and the selected data word.
- Holds the run-time almost-full threshold and a small init/idle/active/error state machine.

Parameters:
- data_width, 10, width of one FIFO word.
- count_width, 4, width of occupancy counts (0..8).
- thr_default, 6, almost-full threshold loaded at reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  while high, the block sits in INIT and tracks thr_in.
- thr_in  input  count_width  almost-full threshold to load (legal 1..8).
- fifo_empty  input  4  empty flags of input FIFOs 0..3.
- fifo_error  input  4  overflow/underflow flags of input FIFOs 0..3.
- fifo_head  input  4*data_width  head word of each input FIFO (first-word-fall-through); FIFO i occupies bits [i*data_width +: data_width].
- out_count  input  count_width  current occupancy of the output FIFO.
- pop  output  4  one-hot pop to the input FIFOs.
- push  output  1  push to the output FIFO.
- data_out  output  data_width  word to the output FIFO.
- state  output  3  current FSM state encoding.
- idle  output  1  high in IDLE.
- error_out  output  1  high in ERROR.

Behaviour:
- Reset (asynchronous, while reset=1):
  - pop=0, push=0, data_out=0, error_out=0, idle=0.
  - state=RESET, thr register=thr_default, rr pointer=0.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET: on the first clk after reset deasserts, go to INIT.
- INIT:
  - thr register <= thr_in every cycle.
  - No pops.
  - When init=0: go to IDLE if &fifo_empty, else ACTIVE.
- IDLE:
  - idle=1, no pops.
  - Go to ACTIVE when any fifo_empty bit is 0; go to INIT when init=1.
- ACTIVE:
  - Grant rule: scan indices ptr, ptr+1, … mod 4 and grant the first non-empty FIFO.
  - Assert pop[g] in the same cycle (combinational from registered state and inputs) only if (out_count + push) < thr register. Here push is the registered push currently in flight.
  - After a grant, ptr <= (g+1) mod 4. With no grant, ptr holds.
  - Return to IDLE when &fifo_empty and no pop this cycle.
  - init=1 goes to INIT; no new pops from that cycle on, and an in-flight push still completes.
- Data latency: a pop of FIFO g in cycle N gives push=1 and data_out=fifo_head[g] in cycle N+1 (registered). Otherwise push=0 and data_out holds its last value.
- Throughput: at most one pop per cycle, so sustained 1 word/cycle when the output has room.
- Backpressure boundary: pops stop when out_count + push ≥ thr. With thr=8 the output FIFO never overflows, because the in-flight word is counted.
- ERROR:
  - Entered from any state except RESET when any fifo_error bit is 1 (takes priority over all other transitions).
  - Sticky: pops stay 0, and the push from a pop in the cycle before entry still occurs.
  - error_out=1.
  - Exit only via reset.
- Simultaneous events: error beats init, which beats normal transitions. A fifo_empty change in the same cycle as a grant is resolved from the current-cycle value.
- Reset mid-stream: an in-flight push is dropped and ptr returns to 0.
- thr_in outside 1..8 is clamped: 0→1, >8→8.

Decomposition:
- Shared package fifo_pkg:
  - State encoding constants (ST_RESET..ST_ERROR).
  - FIFO depth 8 and pointer width 3.
  - data_width default 10.
  - count_width 4.
- Sub-module rr_arbiter4: ptr + request vector (~fifo_empty) + enable → one-hot grant and grant index. Purely combinational.
- The FSM, threshold register, ptr register and data/push register stay in fifo_rr_scheduler.

Test Plan:
- Reset then init: reset=1 for 3 cycles, then init=1 with thr_in=5 for 2 cycles, then init=0 with all FIFOs empty → state goes 0→1→2, idle=1, pop=0, and the thr register reads 5.
- Round-robin: FIFOs 0, 2 and 3 non-empty with heads 0x090, 0x1A9, 0x239; out_count=0; thr=8 → pop sequence 0001, 0100, 1000, 0001. push follows one cycle later with data_out 0x090, 0x1A9, 0x239, 0x090.
- Backpressure: thr=6, out_count=5, push in flight → pop=0. When out_count drops to 4 with push=0, the next pop is asserted. Check that out_count+push never exceeds 6 during the run.
- Single source drain: only FIFO 1 holds 3 words 0x04F, 0x04D, 0x018 → pop[1]=1 for 3 consecutive cycles, the three pushes carry those words in order, and state returns to IDLE the cycle after the last pop.
- Error: fifo_error[2] pulses for 1 cycle during ACTIVE → error_out=1 from the next cycle, pop stays 0 despite non-empty FIFOs, and only reset clears it.
- Mid-run init: init=1 while ACTIVE → no further pops, the pending push completes, the new thr_in=3 is loaded, and init=0 resumes in ACTIVE with ptr unchanged.
